router_port_arbiter: RTL and testbench
======================================

// Module: router_port_arbiter
// PURPOSE
// Round-robin arbiter for one router output port (N, S, E, W or local NI) in the
// mesh NoC. Requests come from the router's other input ports. One winning APB
// packet per transfer goes into a registered output stage. The stage holds the
// packet until the downstream neighbour (or NI) accepts it. A stall watchdog flags
// a downstream that stops accepting. The router instantiates one per output port.
// PARAMETERS
// N_REQ         5                 number of requesting input ports (>=1)
// PACKET_WIDTH  APB_PACKET_WIDTH  packet width in bits (pa_noc)
// STALL_LIMIT   64                cycles o_valid may wait unaccepted before o_stalled; >=1
// PORTS
// i_clk      in   1                     clock, all logic on rising edge
// i_srst     in   1                     synchronous reset, active-high
// i_req      in   N_REQ                 per-requester packet-pending flag
// i_packet   in   N_REQ*PACKET_WIDTH    per-requester packet, [i] valid when i_req[i]
// o_grant    out  N_REQ                 one-hot, comb; [i]=1 -> packet i captured this cycle
// o_valid    out  1                     output stage holds a packet
// o_packet   out  PACKET_WIDTH          registered winning packet
// i_ready    in   1                     downstream accepts o_packet when o_valid&i_ready
// o_stalled  out  1                     o_valid held >= STALL_LIMIT cycles without accept
// BEHAVIOUR
// - Reset, synchronous, wins over all other events: state=IDLE, ptr=0, o_valid=0,
//   o_packet='0, stall_cnt=0, o_stalled=0. o_grant=0 while i_srst=1.
// - Reset mid-transfer drops the held packet silently. No grant is issued in the
//   reset cycle.
// - Priority: the search starts at index ptr and wraps N_REQ-1 -> 0. The first set
//   i_req wins.
// - ptr update: on each capture, ptr <= (winner+1) mod N_REQ. No other event
//   changes ptr.
// - State IDLE (o_valid=0):
//   * Any i_req set: o_grant[winner]=1, o_packet <= i_packet[winner], o_valid <= 1,
//     next state BUSY. Capture-to-o_valid latency is 1 cycle.
//   * No request: stay in IDLE. i_ready is ignored in IDLE.
// - State BUSY (o_valid=1): o_packet is held stable and o_grant=0 while i_ready=0.
// - BUSY with i_ready=1 (transfer):
//   * Any i_req set: capture back-to-back in the same cycle. The winner is searched
//     from the current ptr. o_grant pulses and o_packet is reloaded. Stay in BUSY,
//     o_valid stays 1. No bubble.
//   * No request: o_valid <= 0, next state IDLE.
// - Requester contract: the packet is consumed in the cycle o_grant[i]=1. The
//   requester must present its next packet or deassert i_req in the following cycle.
// - o_grant is one-hot or zero. Grant is given only when the output stage is empty
//   or being emptied in that cycle.
// - Watchdog: stall_cnt is a $clog2(STALL_LIMIT+1)-bit counter.
//   * Increments each cycle with o_valid&!i_ready. Saturates at STALL_LIMIT.
//   * Clears to 0 on transfer or when o_valid=0.
//   * o_stalled = (stall_cnt==STALL_LIMIT), registered. It clears the cycle after
//     a transfer.
// - Degenerate N_REQ=1: ptr stays 0 and the block acts as a 1-deep pipeline stage.
// TESTING
// - Reset check: assert i_srst with i_req=5'b11111 -> o_valid=0, o_grant=0,
//   o_packet=0, o_stalled=0.
// - Single request: i_req=5'b00100 with i_ready=1 ->
//   * o_grant=5'b00100 in the capture cycle;
//   * o_valid=1 with o_packet=i_packet[2] one cycle later;
//   * ptr=3.
// - Fairness: i_req=5'b11111 held, i_ready=1, from reset -> grants 0,1,2,3,4,0 on
//   consecutive cycles and o_valid is continuously 1.
// - Backpressure: after a capture, hold i_ready=0 for 10 cycles with i_req=5'b00011
//   -> o_packet is stable and o_grant=0. On i_ready=1, packet 1 is granted
//   (ptr=1 after winner 0).
// - Watchdog: STALL_LIMIT=4, o_valid=1, i_ready=0 -> o_stalled rises after 4 stalled
//   cycles. It stays high and falls the cycle after i_ready=1.
// - Wrap and reset mid-op: with ptr=4 and i_req=5'b00011 -> grant 0.
//   * Assert i_srst while BUSY -> o_valid=0 next cycle.
//   * The next grant searches from ptr=0.

Source files
------------

// File: rtl/router_port_arbiter.sv
// Round-robin arbiter for one router output port with a registered output stage
// that holds the winning packet until accepted downstream, plus a stall watchdog.
module router_port_arbiter #(
  parameter int unsigned N_REQ        = 5,
  parameter int unsigned PACKET_WIDTH = 32,
  parameter int unsigned STALL_LIMIT  = 64
) (
  input  logic                            i_clk,
  input  logic                            i_srst,
  input  logic [N_REQ-1:0]                i_req,
  input  logic [N_REQ*PACKET_WIDTH-1:0]   i_packet,
  output logic [N_REQ-1:0]                o_grant,
  output logic                            o_valid,
  output logic [PACKET_WIDTH-1:0]         o_packet,
  input  logic                            i_ready,
  output logic                            o_stalled
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    stalled_q, stalled_d;

  logic                    found_hi, found_lo, found;
  int unsigned             win_hi, win_lo, win;
  logic [PACKET_WIDTH-1:0] win_pkt;
  logic [N_REQ-1:0]        grant;
  logic                    xfer, can_grant;

  // Two-pass search: lowest requester at or above ptr, else lowest below ptr,
  // which is the same as a wrapping search starting at ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = 0;
    win_lo   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i_req[i] && (i >= 32'(ptr_q)) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = i;
      end
      if (i_req[i] && (i < 32'(ptr_q)) && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = i;
      end
    end
    found   = found_hi | found_lo;
    win     = found_hi ? win_hi : win_lo;
    win_pkt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i == win) win_pkt = i_packet[i*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pkt_d     = pkt_q;
    grant     = '0;
    xfer      = (state_q == BUSY) && i_ready;
    can_grant = !i_srst && ((state_q == IDLE) || i_ready);

    if (can_grant && found) begin
      for (int unsigned i = 0; i < N_REQ; i++) grant[i] = (i == win);
      pkt_d   = win_pkt;
      ptr_d   = (win == N_REQ - 1) ? '0 : PTR_W'(win + 1);
      state_d = BUSY;
    end else if (xfer) begin
      state_d = IDLE;
    end

    if ((state_q == BUSY) && !i_ready) begin
      cnt_d = (cnt_q == CNT_W'(STALL_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    stalled_d = (cnt_d == CNT_W'(STALL_LIMIT));
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      pkt_q     <= '0;
      cnt_q     <= '0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pkt_q     <= pkt_d;
      cnt_q     <= cnt_d;
      stalled_q <= stalled_d;
    end
  end

  assign o_grant   = grant;
  assign o_valid   = (state_q == BUSY);
  assign o_packet  = pkt_q;
  assign o_stalled = stalled_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Scoreboard bench for router_port_arbiter: directed steps push expected packets,
// a negedge monitor pops and compares on every accepted transfer.
module tb_router_port_arbiter;
  localparam int unsigned NR = 5;
  localparam int unsigned PW = 16;
  localparam int unsigned SL = 4;

  logic           clk;
  logic           i_srst;
  logic [NR-1:0]  i_req;
  logic [NR*PW-1:0] i_packet;
  logic [NR-1:0]  o_grant;
  logic           o_valid;
  logic [PW-1:0]  o_packet;
  logic           i_ready;
  logic           o_stalled;

  int unsigned    vectors = 0;
  int unsigned    errors  = 0;
  logic [7:0]     tag = 8'h00;
  logic [PW-1:0]  exp_q[$];

  router_port_arbiter #(
    .N_REQ(NR),
    .PACKET_WIDTH(PW),
    .STALL_LIMIT(SL)
  ) dut (
    .i_clk(clk),
    .i_srst(i_srst),
    .i_req(i_req),
    .i_packet(i_packet),
    .o_grant(o_grant),
    .o_valid(o_valid),
    .o_packet(o_packet),
    .i_ready(i_ready),
    .o_stalled(o_stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Applies one cycle of stimulus from posedge+1, checks at posedge+4.
  task automatic step(input logic srst, input logic [NR-1:0] req, input logic rdy,
                      input logic [NR-1:0] eg, input logic ev, input logic es);
    int unsigned idx;
    i_srst  = srst;
    i_req   = req;
    i_ready = rdy;
    tag     = tag + 8'd1;
    for (int unsigned i = 0; i < NR; i++) i_packet[i*PW +: PW] = {tag, 8'(i)};
    idx = 0;
    for (int unsigned i = 0; i < NR; i++) if (eg[i]) idx = i;
    if (eg != '0) exp_q.push_back({tag, 8'(idx)});
    #3;
    chk("grant", 32'(o_grant), 32'(eg));
    chk("valid", 32'(o_valid), 32'(ev));
    chk("stalled", 32'(o_stalled), 32'(es));
    if (ev && exp_q.size() > 0) chk("held_packet", 32'(o_packet), 32'(exp_q[0]));
    @(posedge clk);
    #1;
    if (srst) exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!i_srst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_transfer at %0t: got packet %h expected none", $time, o_packet);
      end else begin
        chk("xfer_packet", 32'(o_packet), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_srst = 1'b1; i_req = '1; i_ready = 1'b1; i_packet = '0;
    @(posedge clk); #1;
    // reset with all requests pending
    step(1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0);
    chk("reset_packet", 32'(o_packet), 32'h0);

    // single request, then verify ptr=3 via requesters 0 and 3
    step(1'b0, 5'b00100, 1'b1, 5'b00100, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0);
    step(1'b0, 5'b01001, 1'b1, 5'b01000, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);

    // fairness from reset
    step(1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b11111, 1'b1, 5'b00001, 1'b0, 1'b0);
    step(1'b0, 5'b11111, 1'b1, 5'b00010, 1'b1, 1'b0);
    step(1'b0, 5'b11111, 1'b1, 5'b00100, 1'b1, 1'b0);
    step(1'b0, 5'b11111, 1'b1, 5'b01000, 1'b1, 1'b0);
    step(1'b0, 5'b11111, 1'b1, 5'b10000, 1'b1, 1'b0);
    step(1'b0, 5'b11111, 1'b1, 5'b00001, 1'b1, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);

    // backpressure and watchdog
    step(1'b1, 5'b00011, 1'b1, 5'b00000, 1'b0, 1'b0);
    step(1'b0, 5'b00011, 1'b1, 5'b00001, 1'b0, 1'b0);
    for (int s = 1; s <= 10; s++)
      step(1'b0, 5'b00011, 1'b0, 5'b00000, 1'b1, (s > 4));
    step(1'b0, 5'b00011, 1'b1, 5'b00010, 1'b1, 1'b1);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);

    // drive ptr to 4, wrap to 0, then reset while busy
    step(1'b0, 5'b00100, 1'b1, 5'b00100, 1'b0, 1'b0);
    step(1'b0, 5'b01000, 1'b1, 5'b01000, 1'b1, 1'b0);
    step(1'b0, 5'b00011, 1'b1, 5'b00001, 1'b1, 1'b0);
    step(1'b1, 5'b00011, 1'b1, 5'b00000, 1'b1, 1'b0);
    step(1'b0, 5'b00011, 1'b0, 5'b00001, 1'b0, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0);
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
